// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_CH = 4;
  typedef logic [1:0] ch_sel_t;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice with a delivered-beat counter.
// Handshake: a beat moves on a rising edge where valid_o & ready_i.
module demux_out_slot #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [W-1:0]     data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  assign deliver = valid_q & ready_i;

  // A load wins over a drain so the slot can reload on the edge it empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted beat lands in the
// slot addressed by in_sel; a stalled channel only blocks beats sent to it.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  ch_sel_t               in_sel,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*W-1:0]     out_data,
  output logic [N_CH*CNT_W-1:0] out_cnt
);
  logic [N_CH-1:0] load;
  logic            accept;

  // Ready looks only at the addressed slot, never at in_valid.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    load[in_sel] = accept;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_out_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*W +: W]),
      .cnt_o   (out_cnt[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream against a per-channel queue model.
module tb_demux_1_4_stream;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each channel is a FIFO of beats not yet delivered.
  logic [3:0] exp_q[4][$];
  logic [7:0] m_cnt[4];
  logic       exp_rdy;
  logic       obs_rdy;

  demux_1_4_stream #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      m_cnt[k] = 8'd0;
    end
  endtask

  // Called at a falling edge; applies one cycle of stimulus and advances the model.
  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] r);
    logic acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (exp_q[s].size() == 0) || r[s];
    obs_rdy = in_ready;
    acc     = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (exp_q[k].size() != 0 && r[k]) begin
        void'(exp_q[k].pop_front());
        m_cnt[k] = m_cnt[k] + 8'd1;
      end
    end
    if (acc) exp_q[s].push_back(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;
    model_clear();
    #3;
    n_vec++;
    if (out_valid !== 4'h0 || out_data !== 16'h0 || out_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_initial: valid=%h data=%h cnt=%h required 0/0/0",
               out_valid, out_data, out_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 4'h6, 4'hF);
    drive(1'b0, 2'd0, 4'h0, 4'hF);
    drive(1'b1, 2'd2, 4'hB, 4'h0);
    n_vec++;
    if (out_valid[2] !== 1'b1 || out_cnt[16 +: 8] !== m_cnt[2]) begin
      n_err++;
      $display("FAIL reset_precond: valid2=%b cnt2=%0d required 1/%0d",
               out_valid[2], out_cnt[16 +: 8], m_cnt[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_vec++;
    if (out_valid !== 4'h0 || out_cnt !== 32'h0 || out_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_async: valid=%h cnt=%h data=%h required 0/0/0",
               out_valid, out_cnt, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'h0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready sel%0d: in_ready=%b required 1", s, in_ready);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_basic_routing();
    logic [3:0] vals[4];
    vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'hC; vals[3] = 4'h3;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), vals[k], 4'hF);
      n_vec++;
      if (out_valid[k] !== 1'b1 || out_data[k*4 +: 4] !== vals[k] || obs_rdy !== exp_rdy) begin
        n_err++;
        $display("FAIL route ch%0d: valid=%b data=%h rdy=%b required 1/%h/%b",
                 k, out_valid[k], out_data[k*4 +: 4], obs_rdy, vals[k], exp_rdy);
      end
    end
    drive(1'b0, 2'd0, 4'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (out_cnt[k*8 +: 8] !== 8'd1 || m_cnt[k] !== 8'd1) begin
        n_err++;
        $display("FAIL route_cnt ch%0d: cnt=%0d model=%0d required 1",
                 k, out_cnt[k*8 +: 8], m_cnt[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd1, 4'h7, 4'b1101);
    n_vec++;
    if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h7) begin
      n_err++;
      $display("FAIL bp_hold: valid1=%b data1=%h required 1/7", out_valid[1], out_data[7:4]);
    end
    drive(1'b1, 2'd1, 4'h9, 4'b1101);
    n_vec++;
    if (obs_rdy !== 1'b0 || out_data[7:4] !== 4'h7) begin
      n_err++;
      $display("FAIL bp_stall: in_ready=%b data1=%h required 0/7", obs_rdy, out_data[7:4]);
    end
    drive(1'b1, 2'd0, 4'h2, 4'b1101);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h2
        || out_data[7:4] !== 4'h7) begin
      n_err++;
      $display("FAIL bp_isolate: rdy=%b valid0=%b data0=%h data1=%h required 1/1/2/7",
               obs_rdy, out_valid[0], out_data[3:0], out_data[7:4]);
    end
    drive(1'b1, 2'd1, 4'h9, 4'hF);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h9) begin
      n_err++;
      $display("FAIL bp_release: rdy=%b valid1=%b data1=%h required 1/1/9",
               obs_rdy, out_valid[1], out_data[7:4]);
    end
    drive(1'b0, 2'd0, 4'h0, 4'hF);
    n_vec++;
    if (out_valid !== 4'h0 || out_cnt[15:8] !== 8'd3 || m_cnt[1] !== 8'd3) begin
      n_err++;
      $display("FAIL bp_drain: valid=%h cnt1=%0d required 0/3", out_valid, out_cnt[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c0;
    c0 = m_cnt[3];
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd3, 4'(i), 4'hF);
      n_vec++;
      if (obs_rdy !== 1'b1 || out_valid[3] !== 1'b1 || out_data[15:12] !== 4'(i)) begin
        n_err++;
        $display("FAIL b2b beat%0d: rdy=%b valid3=%b data3=%h required 1/1/%h",
                 i, obs_rdy, out_valid[3], out_data[15:12], 4'(i));
      end
    end
    drive(1'b0, 2'd0, 4'h0, 4'hF);
    n_vec++;
    if (out_cnt[31:24] !== c0 + 8'd16 || out_valid[3] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_cnt: cnt3=%0d valid3=%b required %0d/0",
               out_cnt[31:24], out_valid[3], c0 + 8'd16);
    end
  endtask

  task automatic test_drain_load();
    logic [7:0] c0;
    drive(1'b1, 2'd0, 4'h1, 4'h0);
    c0 = out_cnt[7:0];
    drive(1'b1, 2'd0, 4'hE, 4'b0001);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'hE
        || out_cnt[7:0] !== c0 + 8'd1) begin
      n_err++;
      $display("FAIL drain_load: rdy=%b valid0=%b data0=%h cnt0=%0d required 1/1/e/%0d",
               obs_rdy, out_valid[0], out_data[3:0], out_cnt[7:0], c0 + 8'd1);
    end
    drive(1'b0, 2'd0, 4'h0, 4'hF);
  endtask

  task automatic test_counter_wrap();
    logic [7:0] start[4];
    for (int k = 0; k < 4; k++) start[k] = out_cnt[k*8 +: 8];
    for (int i = 0; i < 256; i++) drive(1'b1, 2'd2, 4'($urandom_range(0, 15)), 4'b0100);
    drive(1'b0, 2'd0, 4'h0, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (out_cnt[k*8 +: 8] !== start[k] || out_cnt[k*8 +: 8] !== m_cnt[k]) begin
        n_err++;
        $display("FAIL wrap ch%0d: cnt=%0d required %0d", k, out_cnt[k*8 +: 8], start[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      n_vec++;
      if (obs_rdy !== exp_rdy) begin
        n_err++;
        $display("FAIL rand_ready cyc%0d: in_ready=%b required %b", i, obs_rdy, exp_rdy);
      end
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (out_valid[k] !== (exp_q[k].size() != 0) || out_cnt[k*8 +: 8] !== m_cnt[k]
            || (exp_q[k].size() != 0 && out_data[k*4 +: 4] !== exp_q[k][0])) begin
          n_err++;
          $display("FAIL rand_out cyc%0d ch%0d: valid=%b data=%h cnt=%0d required %b/%h/%0d",
                   i, k, out_valid[k], out_data[k*4 +: 4], out_cnt[k*8 +: 8],
                   exp_q[k].size() != 0, (exp_q[k].size() != 0) ? exp_q[k][0] : 4'h0,
                   m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_backpressure();
    test_back_to_back();
    test_drain_load();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer. It routes each accepted input beat to one of four output channels, chosen by a 2-bit select. Each channel has a valid/ready handshake.
- This is the distribution-side counterpart of the 4:1 data muxes used on the combining side. It sits between a single producer and four consumers.
- Each channel holds one beat in its own output slot, so a stalled consumer blocks only the beats addressed to it.

Parameters:
- W, 4, data width of one beat.
- CNT_W, 8, width of each per-channel delivered-beat counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  beat accepted this cycle when in_valid & in_ready.
- in_data  input  W  beat payload.
- in_sel  input  2  destination channel 0..3, sampled only on acceptance.
- out_valid  output  4  per-channel slot holds a beat.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*W  channel k payload on bits [k*W +: W].
- out_cnt  output  4*CNT_W  channel k count of beats delivered (out_valid[k] & out_ready[k]) on bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_cnt = 0. Any held beats are discarded. No handshake completes while rst_n is low.
- Reset release: first acceptance is possible on the first rising edge with rst_n high.
- in_ready is combinational: in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - Depends only on the addressed channel's slot.
  - Deliberately independent of in_valid.
- Acceptance: on an edge where in_valid & in_ready, slot[in_sel] loads in_data and out_valid[in_sel] = 1.
- Latency: the beat appears on out_data/out_valid the cycle after acceptance. There is no combinational in-to-out data path.
- Delivery: on an edge where out_valid[k] & out_ready[k] and no new load to k, out_valid[k] clears.
- Simultaneous drain and load on the same channel k: the slot reloads with the new beat and out_valid[k] stays 1. This gives full throughput of one beat per cycle per channel.
- Loads and drains on different channels are independent in the same cycle.
- Stability: while out_valid[k] & ~out_ready[k], out_data for channel k holds its value. out_data[k] after a drain (slot empty) keeps its last value; consumers must not rely on it.
- in_sel and in_data are don't-care when in_valid = 0. Beats are never dropped, duplicated or reordered within a channel.
- Counters:
  - out_cnt[k] increments by 1 on each delivery edge of channel k.
  - Wraps modulo 2^CNT_W (255 -> 0 for the default CNT_W).
  - Cleared only by reset.
- Reset asserted mid-transfer: all slots empty and counters zero immediately, independent of clk.

Decomposition:
- Shared package demux_pkg:
  - constant N_CH = 4.
  - typedef ch_sel_t = logic [1:0].
- One sub-module is natural: demux_out_slot.
  - One-entry register slice with load, data in, ready in; valid/data out; delivered-count output.
  - Instantiated four times via generate.
  - Top level contains only in_ready selection, one-hot load decode of in_sel, and output packing.

Test Plan:
- Reset:
  - Drive rst_n = 0 mid-cycle with a beat held in channel 2 -> out_valid = 0000, out_cnt = 0 immediately, without a clock edge.
  - After release, in_ready = 1 for all in_sel.
- Basic routing:
  - All out_ready = 1; send 4'hA sel 0, 4'h5 sel 1, 4'hC sel 2, 4'h3 sel 3 on consecutive cycles.
  - Expect each value on its channel exactly one cycle after acceptance.
  - Expect out_cnt = 1,1,1,1.
- Backpressure isolation:
  - out_ready[1] = 0; send 4'h7 sel 1, then 4'h9 sel 1, then 4'h2 sel 0.
  - Expect 4'h7 held on ch1; in_ready = 0 while presenting the second sel 1 beat; in_ready = 1 for the sel 0 beat, with 4'h2 delivered on ch0.
  - Raising out_ready[1] delivers 4'h7, then 4'h9.
- Full throughput:
  - out_ready[3] = 1; stream 16 beats 0..F all sel 3 back-to-back.
  - Expect in_ready constantly 1, outputs 0..F in order one per cycle, out_cnt[3] = 16.
- Simultaneous drain/load:
  - ch0 holds 4'h1; out_ready[0] = 1 while a new beat 4'hE is accepted for sel 0 on the same edge.
  - Expect out_valid[0] to stay 1, data 4'hE next cycle, out_cnt[0] +1.
- Counter wrap:
  - Deliver 256 beats on ch2 -> out_cnt[2] returns to 0; other counters unchanged.
